mdu_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the M-extension unit in the EX stage. It accepts a MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request while the instruction sits in EX and runs a fixed-latency multiply or a 32-step restoring divide. It drives mul_stall_o/div_stall_o to freeze the EX/MEM register, then presents the result for exactly the cycle in which the pipeline advances.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the M-extension sequencer.
//   - mdu_state_e      : sequencer FSM states
//   - *_FUNCT3         : RV32M funct3 encodings
//   - DIV_STEPS        : restoring-divide iterations
//   - OVF_*            : the one signed-divide overflow case (INT_MIN / -1)
//   - neg_if()         : conditional two's-complement negate
package mdu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  localparam logic [2:0] MUL_FUNCT3    = 3'b000;
  localparam logic [2:0] MULH_FUNCT3   = 3'b001;
  localparam logic [2:0] MULHSU_FUNCT3 = 3'b010;
  localparam logic [2:0] MULHU_FUNCT3  = 3'b011;
  localparam logic [2:0] DIV_FUNCT3    = 3'b100;
  localparam logic [2:0] DIVU_FUNCT3   = 3'b101;
  localparam logic [2:0] REM_FUNCT3    = 3'b110;
  localparam logic [2:0] REMU_FUNCT3   = 3'b111;

  localparam int DIV_STEPS = 32;

  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem_i/quo_i : partial remainder and remaining dividend bits (quotient
//                 bits shift in at the bottom as dividend bits shift out)
//   dsr_i       : divisor magnitude
//   rem_o/quo_o : values after shifting {rem,quo} left by one and doing the
//                 trial subtract
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in XLEN+1 bits and the top bit of the trial difference is a clean
  // borrow flag.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {1'b0, dsr_i};
  assign rem_o   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: multi-cycle MUL/DIV sequencer for the EX stage.
//   clk_i, rst_i (async, active-low)
//   en_i, op_i, alu1_i, alu2_i : MDU instruction in EX and its operands
//   busywait_i                  : memory stall, holds the finished result
//   flush_i                     : kill the EX instruction
//   result_o, valid_o           : result, valid for the cycles spent in S_DONE
//   mul_stall_o, div_stall_o    : freeze EX/MEM while the operation runs
//   dbg_state_o                 : current FSM state for observation
//
// Handshake: valid_o is high in every S_DONE cycle; the result is consumed
// on the first rising edge where valid_o=1 and busywait_i=0, and the FSM
// returns to S_IDLE at that same edge. A new request is accepted in any
// S_IDLE cycle with en_i=1 and flush_i=0.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] alu1_i,
  input  logic [XLEN-1:0] alu2_i,
  input  logic            busywait_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            mul_stall_o,
  output logic            div_stall_o,
  output mdu_state_e      dbg_state_o
);

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   step_rem, step_quo;
  logic [2*XLEN-1:0] a_ext, b_ext;
  logic              a_sx, b_sx;
  logic              div_signed, a_neg_in, b_neg_in;
  logic              active;

  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // rs1 is signed for everything but MULHU; rs2 only for MUL/MULH.
  // The low 64 bits of the 33x33 signed product equal the product of the
  // 64-bit extended operands, so the multiply is done at 2*XLEN directly.
  assign a_sx  = ~(op_i[1] & op_i[0]);
  assign b_sx  = ~op_i[1];
  assign a_ext = {{XLEN{a_sx & alu1_i[XLEN-1]}}, alu1_i};
  assign b_ext = {{XLEN{b_sx & alu2_i[XLEN-1]}}, alu2_i};

  assign div_signed = ~op_i[0];
  assign a_neg_in   = div_signed & alu1_i[XLEN-1];
  assign b_neg_in   = div_signed & alu2_i[XLEN-1];

  // Reset also drops the stalls so every output reads 0 while rst_i is low.
  assign active      = en_i & ~flush_i & rst_i;
  assign mul_stall_o = active & ~op_i[2] & (state_q != S_DONE);
  assign div_stall_o = active &  op_i[2] & (state_q != S_DONE);

  assign valid_o     = (state_q == S_DONE);
  assign result_o    = result_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (en_i && !flush_i) begin
          op_d    = op_i;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          if (!op_i[2]) begin
            prod_d  = a_ext * b_ext;
            cnt_d   = 5'(MUL_LATENCY - 1);
            state_d = S_MUL;
          end else if (alu2_i == '0) begin
            result_d = op_i[1] ? alu1_i : '1;
            state_d  = S_DONE;
          end else if (div_signed && alu1_i == OVF_DIVIDEND && alu2_i == OVF_DIVISOR) begin
            result_d = op_i[1] ? '0 : OVF_DIVIDEND;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = neg_if(alu1_i, a_neg_in);
            dsr_d   = neg_if(alu2_i, b_neg_in);
            cnt_d   = 5'(DIV_STEPS - 1);
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) begin
          result_d = (op_q == MUL_FUNCT3) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        // Sign flags are only ever set for DIV/REM, so unsigned ops pass through.
        result_d = op_q[1] ? neg_if(rem_q, a_neg_q) : neg_if(quo_q, a_neg_q ^ b_neg_q);
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!busywait_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush, or the instruction vanishing from EX mid-operation, abandons
    // the operation without producing a result.
    if (flush_i || (!en_i && state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: scoreboard bench for mdu_seq_ctrl. The driver pushes the
// expected result, stall length and stall kind of every request; a negedge
// monitor checks them whenever the DUT presents a result.
module tb_mdu_seq_ctrl;
  import mdu_pkg::*;

  localparam int ML = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [2:0]  op_i;
  logic [31:0] alu1_i;
  logic [31:0] alu2_i;
  logic        busywait_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic        mul_stall_o;
  logic        div_stall_o;
  mdu_state_e  dbg_state_o;

  mdu_seq_ctrl #(.XLEN(32), .MUL_LATENCY(ML)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .op_i        (op_i),
    .alu1_i      (alu1_i),
    .alu2_i      (alu2_i),
    .busywait_i  (busywait_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .mul_stall_o (mul_stall_o),
    .div_stall_o (div_stall_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  bit          div_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      MUL_FUNCT3:    begin p = sa * sb; return p[31:0];  end
      MULH_FUNCT3:   begin p = sa * sb; return p[63:32]; end
      MULHSU_FUNCT3: begin p = sa * ub; return p[63:32]; end
      MULHU_FUNCT3:  begin p = ua * ub; return p[63:32]; end
      DIV_FUNCT3:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      DIVU_FUNCT3:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      REM_FUNCT3:    return (b == 0) ? a : 32'(sa % sb);
      default:       return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1 + ML;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  int stall_cnt = 0;
  bit saw_mul = 0;
  bit saw_div = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      stall_cnt = 0; saw_mul = 0; saw_div = 0;
    end else begin
      if (flush_i) begin
        check("stall_during_flush", {30'b0, mul_stall_o, div_stall_o}, 32'h0);
        stall_cnt = 0; saw_mul = 0; saw_div = 0;
      end else if (mul_stall_o || div_stall_o) begin
        stall_cnt++;
        saw_mul |= mul_stall_o;
        saw_div |= div_stall_o;
      end
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'b0, valid_o}, 32'h0);
        end else begin
          check("result", result_o, exp_q[0]);
          check("stall_in_done", {30'b0, mul_stall_o, div_stall_o}, 32'h0);
          if (!busywait_i) begin
            check("stall_cycles", 32'(stall_cnt), 32'(lat_q[0]));
            check("stall_kind", {30'b0, saw_mul, saw_div}, div_q[0] ? 32'h1 : 32'h2);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(div_q.pop_front());
            stall_cnt = 0; saw_mul = 0; saw_div = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each task starts and ends 1 time unit after a rising edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int busy);
    int guard;
    op_i = op; alu1_i = a; alu2_i = b; en_i = 1'b1; flush_i = 1'b0;
    busywait_i = (busy > 0);
    exp_q.push_back(model(op, a, b));
    lat_q.push_back(lat_of(op, a, b));
    div_q.push_back(op[2]);
    @(negedge clk_i);
    check("idle_at_capture", 32'(dbg_state_o), 32'(S_IDLE));
    guard = 0;
    while (!valid_o && guard < 100) begin
      @(posedge clk_i); #1;
      alu1_i = $urandom;  // must be ignored after capture
      alu2_i = $urandom;
      @(negedge clk_i);
      guard++;
    end
    if (!valid_o) begin
      check("valid_timeout", {31'b0, valid_o}, 32'h1);
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      void'(div_q.pop_back());
    end else begin
      for (int i = 0; i < busy; i++) begin
        @(posedge clk_i); #1;
        if (i == busy - 1) busywait_i = 1'b0;
        @(negedge clk_i);
      end
    end
    @(posedge clk_i); #1;
    en_i = 1'b0;
    busywait_i = 1'b0;
  endtask

  task automatic idle(input int n);
    en_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic do_flush_test();
    op_i = DIV_FUNCT3; alu1_i = 32'd1000; alu2_i = 32'd7; en_i = 1'b1; flush_i = 1'b0;
    repeat (10) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    en_i = 1'b0;
    @(negedge clk_i);
    check("flush_state", 32'(dbg_state_o), 32'(S_IDLE));
    check("flush_valid", {31'b0, valid_o}, 32'h0);
    check("flush_stalls", {30'b0, mul_stall_o, div_stall_o}, 32'h0);
    @(posedge clk_i); #1;
    idle(40);  // monitor flags any late valid
  endtask

  task automatic do_reset_test();
    op_i = DIV_FUNCT3; alu1_i = 32'd12345; alu2_i = 32'd3; en_i = 1'b1; flush_i = 1'b0;
    repeat (6) begin @(posedge clk_i); #1; end
    #2;
    rst_i = 1'b0;
    #1;
    check("async_rst_result", result_o, 32'h0);
    check("async_rst_valid", {31'b0, valid_o}, 32'h0);
    check("async_rst_stalls", {30'b0, mul_stall_o, div_stall_o}, 32'h0);
    check("async_rst_state", 32'(dbg_state_o), 32'(S_IDLE));
    en_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b0; en_i = 1'b0; op_i = '0; alu1_i = '0; alu2_i = '0;
    busywait_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_result", result_o, 32'h0);
    check("reset_valid", {31'b0, valid_o}, 32'h0);
    check("reset_stalls", {30'b0, mul_stall_o, div_stall_o}, 32'h0);
    check("reset_state", 32'(dbg_state_o), 32'(S_IDLE));
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // directed cases, issued back-to-back
    do_op(MUL_FUNCT3,    32'd7,          32'hFFFF_FFFD, 0);
    do_op(MULHU_FUNCT3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    do_op(MULHSU_FUNCT3, 32'hFFFF_FFFF,  32'd2,         0);
    do_op(DIV_FUNCT3,    32'hFFFF_FFF9,  32'd2,         0);
    do_op(REM_FUNCT3,    32'hFFFF_FFF9,  32'd2,         0);
    do_op(DIVU_FUNCT3,   32'd100,        32'd7,         4);
    do_op(DIVU_FUNCT3,   32'd5,          32'd0,         0);
    do_op(REM_FUNCT3,    32'd5,          32'd0,         0);
    do_op(DIV_FUNCT3,    32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op(REM_FUNCT3,    32'h8000_0000,  32'hFFFF_FFFF, 4);
    do_op(MUL_FUNCT3,    32'h1234_5678,  32'h9ABC_DEF0, 4);
    do_op(DIV_FUNCT3,    32'd1000,       32'hFFFF_FFFD, 0);
    do_op(MULH_FUNCT3,   32'h8000_0000,  32'h8000_0000, 0);
    idle(2);

    do_flush_test();

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    do_op(DIVU_FUNCT3, 32'd100, 32'd7, 0);
    do_reset_test();
    do_op(REMU_FUNCT3, 32'd100, 32'd7, 0);
    idle(3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
